// File: rtl/fetch_pkg.sv
// +------------------------------------------------------------------+
// | fetch_pkg: shared constants and FSM encoding for the fetch stage  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// +------------------------------------------------------------------+
// | if_id_reg: IF/ID pipeline register; flush has priority over load  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  output logic [31:0] IDpc,
  output logic [31:0] IDinstruction,
  output logic        IDvalid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = 32'd0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign IDpc          = pc_q;
  assign IDinstruction = instr_q;
  assign IDvalid       = valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +------------------------------------------------------------------+
// | fetch_stage: PC, imem handshake, skid buffer and redirect FSM     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_ctrl,
  input  logic [31:0] MEMpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] IDpc,
  output logic [31:0] IDinstruction,
  output logic        IDvalid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;

  logic         id_load, id_flush, id_valid_in;
  logic [31:0]  id_pc_in, id_instr_in;
  logic         accept;
  logic [31:0]  pc_plus4, branch_pc;

  assign accept    = req_q & imem_ready;
  assign pc_plus4  = pc_q + 32'd4;
  assign branch_pc = MEMpc & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    id_load      = 1'b0;
    id_flush     = 1'b0;
    id_valid_in  = 1'b0;
    id_pc_in     = IDpc;
    id_instr_in  = IDinstruction;

    if (branch_ctrl) begin
      id_flush     = 1'b1;
      skid_pc_d    = 32'd0;
      skid_instr_d = 32'd0;
      pc_d         = branch_pc;
      // Without an accept in FETCH/DRAIN the old request is still in flight and must be drained.
      if (state_q == HOLD || accept) begin
        addr_d  = branch_pc;
        state_d = FETCH;
      end else begin
        state_d = DRAIN;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_pc_d    = pc_plus4;
              skid_instr_d = imem_data;
              state_d      = HOLD;
            end else begin
              addr_d      = pc_plus4;
              id_load     = 1'b1;
              id_pc_in    = pc_plus4;
              id_instr_in = imem_data;
              id_valid_in = 1'b1;
            end
          end else if (!stall) begin
            id_load = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_load     = 1'b1;
            id_pc_in    = skid_pc_q;
            id_instr_in = skid_instr_q;
            id_valid_in = 1'b1;
            addr_d      = pc_q;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          if (accept) begin
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    req_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (id_load),
    .flush        (id_flush),
    .pc_in        (id_pc_in),
    .instr_in     (id_instr_in),
    .valid_in     (id_valid_in),
    .IDpc         (IDpc),
    .IDinstruction(IDinstruction),
    .IDvalid      (IDvalid)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +------------------------------------------------------------------+
// | tb_fetch_stage: directed vector bench for fetch_stage             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_ctrl;
  logic [31:0] MEMpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] IDpc;
  logic [31:0] IDinstruction;
  logic        IDvalid;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_ctrl  (branch_ctrl),
    .MEMpc        (MEMpc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .IDpc         (IDpc),
    .IDinstruction(IDinstruction),
    .IDvalid      (IDvalid)
  );

  always #5 clk = ~clk;

  // Memory model: word = address; ready after `lat` cycles of an outstanding request.
  int lat = 1;
  int wcnt;
  always @(posedge clk or posedge reset) begin
    if (reset)                       wcnt <= 0;
    else if (imem_req && imem_ready) wcnt <= 0;
    else if (imem_req)               wcnt <= wcnt + 1;
  end
  assign imem_ready = imem_req && ((wcnt + 1) >= lat);
  assign imem_data  = imem_addr;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] idpc, input logic [31:0] instr, input logic valid);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"},  imem_addr,         addr);
    chk({tag, ".IDpc"},  IDpc,              idpc);
    chk({tag, ".instr"}, IDinstruction,     instr);
    chk({tag, ".valid"}, {31'd0, IDvalid},  {31'd0, valid});
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] m);
    stall       = s;
    branch_ctrl = b;
    MEMpc       = m;
    @(negedge clk);
  endtask

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] m;
    logic        req;
    logic [31:0] addr;
    logic [31:0] idpc;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  vec_t vt[19];

  initial begin
    // Zero-wait: sequential fetch, stall/skid, branch, PC wrap, flush over stall, branch in HOLD.
    vt[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0004, 32'h0040_0004, 32'h0040_0000, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0008, 32'h0040_0008, 32'h0040_0004, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0008, 32'h0040_0008, 32'h0040_0004, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0008, 32'h0040_0008, 32'h0040_0004, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0008, 32'h0040_0008, 32'h0040_0004, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_000C, 32'h0040_000C, 32'h0040_0008, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0010, 32'h0040_0010, 32'h0040_000C, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 32'h0040_0021, 1'b1, 32'h0040_0020, 32'h0,         32'h0,         1'b0};
    vt[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0024, 32'h0040_0024, 32'h0040_0020, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1};
    vt[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vt[12] = '{1'b0, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000, 32'h0,         32'h0,         1'b0};
    vt[13] = '{1'b1, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 32'h0,         32'h0,         1'b0};
    vt[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0044, 32'h0040_0044, 32'h0040_0040, 1'b1};
    vt[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0044, 32'h0040_0044, 32'h0040_0040, 1'b1};
    vt[16] = '{1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200, 32'h0,         32'h0,         1'b0};
    vt[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0200, 32'h0,         32'h0,         1'b0};
    vt[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0204, 32'h0040_0204, 32'h0040_0200, 1'b1};

    reset       = 1'b1;
    stall       = 1'b0;
    branch_ctrl = 1'b0;
    MEMpc       = 32'd0;

    @(negedge clk);
    chk_all("reset", 1'b0, 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    #2 reset = 1'b0;
    @(negedge clk);
    chk_all("first_req", 1'b1, 32'h0040_0000, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step(vt[i].s, vt[i].b, vt[i].m);
      chk_all($sformatf("v%0d", i), vt[i].req, vt[i].addr, vt[i].idpc, vt[i].instr, vt[i].valid);
    end

    // 3-cycle memory; branch in the first wait cycle must drain the stale response.
    lat = 3;
    step(1'b0, 1'b1, 32'h0040_0100);
    chk_all("lat_br", 1'b1, 32'h0040_0204, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("lat_wait", 1'b1, 32'h0040_0204, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("lat_drain", 1'b1, 32'h0040_0100, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("lat_pend", 1'b1, 32'h0040_0100, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("lat_fetch", 1'b1, 32'h0040_0104, 32'h0040_0104, 32'h0040_0100, 1'b1);

    // Reset asserted while draining takes effect before the next clock edge.
    step(1'b0, 1'b1, 32'h0040_0300);
    chk_all("drain", 1'b1, 32'h0040_0104, 32'h0, 32'h0, 1'b0);
    branch_ctrl = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all("post_rst", 1'b1, 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("post_rst_fetch", 1'b1, 32'h0040_0004, 32'h0040_0004, 32'h0040_0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
